// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the decode/writeback pipeline, the long-latency unit,
// and the register file write-port controller.
interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb_we;
    logic [AW-1:0] wb_rw;
    logic [DW-1:0] wb_wdata;
    logic          lu_valid;
    logic [AW-1:0] lu_rw;
    logic [DW-1:0] lu_wdata;
    logic          lu_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_rw;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_wdata;
    logic          init_busy;

    modport master (
        output wb_we, wb_rw, wb_wdata,
        output lu_valid, lu_rw, lu_wdata,
        output issue_valid, issue_rw, rs, rt,
        input  lu_ready, stall, init_busy,
        input  rf_we, rf_rw, rf_wdata
    );

    modport slave (
        input  wb_we, wb_rw, wb_wdata,
        input  lu_valid, lu_rw, lu_wdata,
        input  issue_valid, issue_rw, rs, rt,
        output lu_ready, stall, init_busy,
        output rf_we, rf_rw, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller: post-reset clear, writeback vs
// long-latency arbitration through a 2-entry buffer, pending scoreboard.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic [DW-1:0] data;
    } ent_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    ent_t            fifo_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] set_v;
    logic [NREG-1:0] clr_v;
    ent_t            head;
    logic            run;
    logic            wb_hit;
    logic            push;
    logic            pop;
    logic            lu_ready;
    logic            init_busy;

    assign run    = (state_q == RUN);
    assign head   = fifo_q[rd_ptr_q];
    assign wb_hit = run && bus.wb_we && (bus.wb_rw != '0);
    assign pop    = run && !wb_hit && (count_q != 2'd0);
    assign push   = bus.lu_valid && lu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (cnt_q == '1) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_rw    = '0;
        bus.rf_wdata = '0;
        init_busy    = 1'b0;
        lu_ready     = 1'b0;
        unique case (state_q)
            INIT: begin
                bus.rf_we = 1'b1;
                bus.rf_rw = cnt_q;
                init_busy = 1'b1;
            end
            RUN: begin
                lu_ready = (count_q != 2'd2);
                unique case (1'b1)
                    wb_hit: begin
                        bus.rf_we    = 1'b1;
                        bus.rf_rw    = bus.wb_rw;
                        bus.rf_wdata = bus.wb_wdata;
                    end
                    pop: begin
                        // A head aimed at r0 still pops, but never writes
                        if (head.rw != '0) begin
                            bus.rf_we    = 1'b1;
                            bus.rf_rw    = head.rw;
                            bus.rf_wdata = head.data;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.lu_ready  = lu_ready;
    assign bus.init_busy = init_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{rw: bus.lu_rw, data: bus.lu_wdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (run && bus.issue_valid && (bus.issue_rw != '0)) begin
            set_v[bus.issue_rw] = 1'b1;
        end
        if (pop && (head.rw != '0)) begin
            clr_v[head.rw] = 1'b1;
        end
        // A re-issue on the retiring destination keeps it pending
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.stall = init_busy
                     | ((bus.rs != '0) && pending_q[bus.rs])
                     | ((bus.rt != '0) && pending_q[bus.rt]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a
// queue-based reference model checked on every negative clock edge.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_init;
    int          m_cnt;
    bit [31:0]   m_pend;

    // Reference model: expectations at negedge, state advance at posedge
    initial begin
        logic        e_we;
        logic [4:0]  e_rw;
        logic [31:0] e_d;
        logic        e_stall;
        bit          wbh;
        bit          dopop;
        bit          dopush;
        ent_t        h;
        m_init = 1;
        m_cnt  = 0;
        m_pend = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_init = 1;
                m_cnt  = 0;
                m_pend = '0;
                mq.delete();
            end
            e_we = 0;
            e_rw = 0;
            e_d  = 0;
            if (m_init) begin
                e_we    = 1;
                e_rw    = 5'(m_cnt);
                e_stall = 1;
            end else begin
                if (bus.wb_we && bus.wb_rw != 0) begin
                    e_we = 1;
                    e_rw = bus.wb_rw;
                    e_d  = bus.wb_wdata;
                end else if (mq.size() > 0 && mq[0].rw != 0) begin
                    e_we = 1;
                    e_rw = mq[0].rw;
                    e_d  = mq[0].d;
                end
                e_stall = (bus.rs != 0 && m_pend[bus.rs])
                       || (bus.rt != 0 && m_pend[bus.rt]);
            end
            chk("rf_we", 32'(bus.rf_we), 32'(e_we));
            chk("rf_rw", 32'(bus.rf_rw), 32'(e_rw));
            chk("rf_wdata", bus.rf_wdata, e_d);
            chk("init_busy", 32'(bus.init_busy), 32'(m_init));
            chk("stall", 32'(bus.stall), 32'(e_stall));
            chk("lu_ready", 32'(bus.lu_ready),
                32'(!m_init && mq.size() < 2));
            @(posedge clk);
            if (rst_n) begin
                if (m_init) begin
                    if (m_cnt == 31) m_init = 0;
                    else m_cnt++;
                end else begin
                    wbh    = bus.wb_we && bus.wb_rw != 0;
                    dopop  = !wbh && mq.size() > 0;
                    dopush = bus.lu_valid && mq.size() < 2;
                    if (dopop) begin
                        h = mq.pop_front();
                        if (h.rw != 0) m_pend[h.rw] = 0;
                    end
                    if (bus.issue_valid && bus.issue_rw != 0)
                        m_pend[bus.issue_rw] = 1;
                    if (dopush) mq.push_back('{bus.lu_rw, bus.lu_wdata});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we       = 0;
        bus.wb_rw       = 0;
        bus.wb_wdata    = 0;
        bus.lu_valid    = 0;
        bus.lu_rw       = 0;
        bus.lu_wdata    = 0;
        bus.issue_valid = 0;
        bus.issue_rw    = 0;
        bus.rs          = 0;
        bus.rt          = 0;
    endtask

    task automatic init_seq(input string tag);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk({tag, "_we"}, 32'(bus.rf_we), 32'd1);
            chk({tag, "_rw"}, 32'(bus.rf_rw), 32'(i));
            chk({tag, "_d"}, bus.rf_wdata, 32'd0);
            cyc();
        end
        #1;
        chk({tag, "_busy_fall"}, 32'(bus.init_busy), 32'd0);
        chk({tag, "_ready_rise"}, 32'(bus.lu_ready), 32'd1);
    endtask

    initial begin
        idle();
        rst_n = 0;
        #2;
        chk("rst_we", 32'(bus.rf_we), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_ready", 32'(bus.lu_ready), 32'd0);
        cyc();
        cyc();
        rst_n = 1;
        init_seq("init");

        bus.wb_we    = 1;
        bus.wb_rw    = 5;
        bus.wb_wdata = 32'hDEADBEEF;
        #1;
        chk("wb5_we", 32'(bus.rf_we), 32'd1);
        chk("wb5_rw", 32'(bus.rf_rw), 32'd5);
        chk("wb5_d", bus.rf_wdata, 32'hDEADBEEF);
        bus.wb_rw = 0;
        #1;
        chk("wb0_we", 32'(bus.rf_we), 32'd0);
        cyc();
        idle();

        bus.issue_valid = 1;
        bus.issue_rw    = 8;
        bus.rs          = 8;
        #1;
        chk("iss8_nostall", 32'(bus.stall), 32'd0);
        cyc();
        bus.issue_valid = 0;
        #1;
        chk("iss8_stall", 32'(bus.stall), 32'd1);
        bus.lu_valid = 1;
        bus.lu_rw    = 8;
        bus.lu_wdata = 32'h12345678;
        cyc();
        bus.lu_valid = 0;
        #1;
        chk("lu8_rw", 32'(bus.rf_rw), 32'd8);
        chk("lu8_d", bus.rf_wdata, 32'h12345678);
        chk("lu8_stall", 32'(bus.stall), 32'd1);
        cyc();
        #1;
        chk("lu8_unstall", 32'(bus.stall), 32'd0);
        idle();

        bus.wb_we    = 1;
        bus.wb_rw    = 1;
        bus.wb_wdata = 32'h0BAD_F00D;
        bus.lu_valid = 1;
        bus.lu_rw    = 3;
        bus.lu_wdata = 32'hAAAA_0003;
        cyc();
        bus.lu_rw    = 4;
        bus.lu_wdata = 32'hBBBB_0004;
        cyc();
        bus.lu_valid = 0;
        #1;
        chk("full_ready", 32'(bus.lu_ready), 32'd0);
        chk("starve_rw", 32'(bus.rf_rw), 32'd1);
        cyc();
        bus.wb_we = 0;
        #1;
        chk("drain3_rw", 32'(bus.rf_rw), 32'd3);
        chk("drain3_d", bus.rf_wdata, 32'hAAAA_0003);
        cyc();
        #1;
        chk("drain4_rw", 32'(bus.rf_rw), 32'd4);
        cyc();
        #1;
        chk("drained_we", 32'(bus.rf_we), 32'd0);

        bus.issue_valid = 1;
        bus.issue_rw    = 9;
        cyc();
        bus.issue_valid = 0;
        bus.lu_valid    = 1;
        bus.lu_rw       = 9;
        bus.lu_wdata    = 32'h9999_9999;
        cyc();
        bus.lu_valid    = 0;
        bus.issue_valid = 1;
        bus.rs          = 9;
        #1;
        chk("same9_pop", 32'(bus.rf_rw), 32'd9);
        cyc();
        bus.issue_valid = 0;
        #1;
        chk("same9_stall", 32'(bus.stall), 32'd1);
        idle();

        bus.issue_valid = 1;
        bus.issue_rw    = 7;
        cyc();
        bus.issue_valid = 0;
        bus.wb_we       = 1;
        bus.wb_rw       = 2;
        bus.lu_valid    = 1;
        bus.lu_rw       = 7;
        bus.lu_wdata    = 32'h7777_7777;
        cyc();
        bus.lu_rw = 10;
        cyc();
        bus.lu_valid = 0;
        #1;
        chk("pre_rst_full", 32'(bus.lu_ready), 32'd0);
        rst_n = 0;
        idle();
        #1;
        chk("mid_rst_rw", 32'(bus.rf_rw), 32'd0);
        chk("mid_rst_busy", 32'(bus.init_busy), 32'd1);
        cyc();
        cyc();
        rst_n = 1;
        init_seq("reinit");
        bus.rs = 7;
        #1;
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_we", 32'(bus.rf_we), 32'd0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                idle();
                cyc();
                rst_n = 1;
            end
            bus.wb_we       = ($urandom_range(0, 99) < 45);
            bus.wb_rw       = 5'($urandom_range(0, 31));
            bus.wb_wdata    = $urandom;
            bus.lu_valid    = ($urandom_range(0, 99) < 40);
            bus.lu_rw       = ($urandom_range(0, 9) == 0) ? 5'd0
                              : 5'($urandom_range(1, 31));
            bus.lu_wdata    = $urandom;
            bus.issue_valid = ($urandom_range(0, 99) < 30);
            bus.issue_rw    = 5'($urandom_range(0, 31));
            bus.rs          = 5'($urandom_range(0, 31));
            bus.rt          = 5'($urandom_range(0, 31));
            cyc();
        end

        idle();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
